// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one load/store in flight,
// fixed programmable latency, word and byte accesses.
module dmem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic        req_byte,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            we_q, we_d;
  logic            byte_q, byte_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;

  logic [31:0]     mem_q [DEPTH];

  logic            accept;
  logic            commit;
  logic            mem_we;
  logic [31:0]     mem_wdata;

  logic            a_we;
  logic            a_byte;
  logic [31:0]     a_addr;
  logic [31:0]     a_wdata;
  logic            a_err;
  logic [AW-1:0]   widx;
  logic [1:0]      lane;
  logic [31:0]     word_rd;
  logic [7:0]      lane_rd;

  assign req_ready  = (state_q == IDLE) && !reset;
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign accept     = req_valid && req_ready;

  // With LATENCY = 1 the commit edge is the accept edge,
  // so the live request fields feed the access path.
  always_comb begin
    a_we    = we_q;
    a_byte  = byte_q;
    a_addr  = addr_q;
    a_wdata = wdata_q;
    if (state_q == IDLE) begin
      a_we    = req_we;
      a_byte  = req_byte;
      a_addr  = req_addr;
      a_wdata = req_wdata;
    end
  end

  assign widx    = a_addr[AW+1:2];
  assign lane    = a_addr[1:0];
  assign word_rd = mem_q[widx];
  assign lane_rd = word_rd[{lane, 3'b000} +: 8];

  always_comb begin
    a_err = 1'b0;
    if (a_addr[31:AW+2] != '0) begin
      a_err = 1'b1;
    end
    if (!a_byte && (a_addr[1:0] != 2'b00)) begin
      a_err = 1'b1;
    end
  end

  always_comb begin
    mem_wdata = a_wdata;
    if (a_byte) begin
      mem_wdata = word_rd;
      mem_wdata[{lane, 3'b000} +: 8] = a_wdata[7:0];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    byte_d  = byte_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          we_d    = req_we;
          byte_d  = req_byte;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (LATENCY == 1) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CW'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (commit) begin
      err_d   = a_err;
      rdata_d = 32'h0;
      if (!a_we && !a_err) begin
        rdata_d = a_byte ? {24'h0, lane_rd} : word_rd;
      end
    end
  end

  assign mem_we = commit && a_we && !a_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      byte_q  <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      byte_q  <= byte_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage is deliberately not reset; committed data survives reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[widx] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a word-array model;
// instance 0 runs LATENCY=2, instance 1 runs LATENCY=4.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst [2];
  logic        rv  [2];
  logic        rr  [2];
  logic        we  [2];
  logic        by  [2];
  logic [31:0] ad  [2];
  logic [31:0] wd  [2];
  logic        pv  [2];
  logic        pr  [2];
  logic [31:0] rd  [2];
  logic        er  [2];

  logic [31:0] mdl [2][64];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(64), .LATENCY(2)) u_dut0 (
    .clk(clk), .reset(rst[0]),
    .req_valid(rv[0]), .req_ready(rr[0]),
    .req_we(we[0]), .req_byte(by[0]),
    .req_addr(ad[0]), .req_wdata(wd[0]),
    .resp_valid(pv[0]), .resp_ready(pr[0]),
    .resp_rdata(rd[0]), .resp_err(er[0])
  );

  dmem_responder #(.DEPTH(64), .LATENCY(4)) u_dut1 (
    .clk(clk), .reset(rst[1]),
    .req_valid(rv[1]), .req_ready(rr[1]),
    .req_we(we[1]), .req_byte(by[1]),
    .req_addr(ad[1]), .req_wdata(wd[1]),
    .resp_valid(pv[1]), .resp_ready(pr[1]),
    .resp_rdata(rd[1]), .resp_err(er[1])
  );

  function automatic int lat(input int s);
    return (s == 0) ? 2 : 4;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic void model(input int s, input bit w, input bit b,
                                input logic [31:0] a,
                                input logic [31:0] wdat,
                                output bit e, output logic [31:0] r);
    int          idx;
    int          ln;
    logic [31:0] word;
    e = (a >= 32'd256) || (!b && (a % 4 != 0));
    r = 32'h0;
    if (e) return;
    idx  = int'(a / 4);
    ln   = int'(a % 4);
    word = mdl[s][idx];
    if (w) begin
      if (b) word[ln*8 +: 8] = wdat[7:0];
      else   word = wdat;
      mdl[s][idx] = word;
    end else begin
      r = b ? ((word >> (8 * ln)) & 32'hFF) : word;
    end
  endfunction

  task automatic idle_inputs(input int s);
    rv[s] = 1'b0;
    we[s] = 1'b0;
    by[s] = 1'b0;
    ad[s] = 32'h0;
    wd[s] = 32'h0;
    pr[s] = 1'b0;
  endtask

  task automatic txn(input int s, input bit w, input bit b,
                     input logic [31:0] a, input logic [31:0] wdat,
                     input int bp);
    int          n;
    bit          e;
    logic [31:0] r;
    model(s, w, b, a, wdat, e, r);
    chk("req_ready_idle", rr[s], 1);
    rv[s] = 1'b1;
    we[s] = w;
    by[s] = b;
    ad[s] = a;
    wd[s] = wdat;
    @(posedge clk);
    #1;
    rv[s] = 1'b0;
    ad[s] = $urandom;
    wd[s] = $urandom;
    chk("req_ready_after_acc", rr[s], 0);
    n = 0;
    while (n < 20) begin
      if (pv[s]) break;
      @(posedge clk);
      #1;
      n++;
      if (!pv[s]) chk("req_ready_wait", rr[s], 0);
    end
    chk("latency", n, lat(s));
    chk("rdata", rd[s], r);
    chk("err", er[s], e);
    for (int i = 0; i < bp; i++) begin
      rv[s] = 1'b1;
      we[s] = 1'b1;
      by[s] = 1'b0;
      ad[s] = $urandom_range(0, 63) * 4;
      wd[s] = $urandom;
      @(posedge clk);
      #1;
      chk("bp_valid", pv[s], 1);
      chk("bp_rdata", rd[s], r);
      chk("bp_err", er[s], e);
      chk("bp_ready", rr[s], 0);
    end
    rv[s] = 1'b0;
    pr[s] = 1'b1;
    @(posedge clk);
    #1;
    pr[s] = 1'b0;
    chk("hs_valid_drop", pv[s], 0);
    chk("hs_ready", rr[s], 1);
  endtask

  initial begin
    bit          w;
    bit          b;
    logic [31:0] a;
    logic [31:0] v;
    int          n;
    for (int s = 0; s < 2; s++) begin
      rst[s] = 1'b1;
      idle_inputs(s);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready0", rr[0], 0);
    chk("rst_ready1", rr[1], 0);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
        chk("idle_ready", rr[s], 1);
        chk("idle_valid", pv[s], 0);
        chk("idle_rdata", rd[s], 0);
        chk("idle_err", er[s], 0);
      end
    end

    for (int i = 0; i < 64; i++) txn(0, 1, 0, i * 4, $urandom, 0);

    txn(0, 1, 0, 32'h10, 32'h12345678, 0);
    txn(0, 0, 0, 32'h10, 32'h0, 0);
    chk("dir_load10", mdl[0][4], 32'h12345678);
    txn(0, 1, 0, 32'h20, 32'hAABBCCDD, 0);
    txn(0, 1, 1, 32'h22, 32'h00000011, 0);
    txn(0, 0, 0, 32'h20, 32'h0, 0);
    txn(0, 0, 1, 32'h23, 32'h0, 0);
    txn(0, 0, 0, 32'h21, 32'h0, 0);
    txn(0, 1, 0, 32'h100, 32'hDEADBEEF, 0);
    txn(0, 0, 0, 32'h0, 32'h0, 0);
    txn(0, 0, 0, 32'h20, 32'h0, 7);

    for (int i = 0; i < 200; i++) begin
      w = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) a = $urandom_range(0, 32'h13F);
      else a = $urandom_range(0, 255);
      if (!b && $urandom_range(0, 7) != 0) a[1:0] = 2'b00;
      txn(0, w, b, a, $urandom, ($urandom_range(0, 5) == 0) ? 2 : 0);
    end

    txn(1, 1, 0, 32'h30, 32'h0, 0);
    rv[1] = 1'b1;
    we[1] = 1'b1;
    by[1] = 1'b0;
    ad[1] = 32'h30;
    wd[1] = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    rv[1] = 1'b0;
    chk("rw_accepted", rr[1], 0);
    repeat (2) @(posedge clk);
    #1;
    rst[1] = 1'b1;
    #1;
    chk("rw_ready_in_rst", rr[1], 0);
    chk("rw_valid_in_rst", pv[1], 0);
    @(posedge clk);
    #1;
    rst[1] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("rw_no_resp", pv[1], 0);
      chk("rw_idle", rr[1], 1);
    end
    txn(1, 0, 0, 32'h30, 32'h0, 0);

    rv[1] = 1'b1;
    we[1] = 1'b0;
    ad[1] = 32'h30;
    @(posedge clk);
    #1;
    rv[1] = 1'b0;
    n = 0;
    while (!pv[1] && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("rr_resp_seen", pv[1], 1);
    rst[1] = 1'b1;
    #1;
    chk("rr_dropped", pv[1], 0);
    @(posedge clk);
    #1;
    rst[1] = 1'b0;
    @(posedge clk);
    #1;
    chk("rr_after_valid", pv[1], 0);
    chk("rr_after_ready", rr[1], 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
